// File: rtl/vga_console_pkg.sv
// Shared definitions for the text-console write controller: control codes and FSM states.
package vga_console_pkg;

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_TAB = 8'h09;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_FF  = 8'h0C;
  localparam logic [7:0] CH_CR  = 8'h0D;

  typedef enum logic [1:0] {
    INIT_CLEAR,
    IDLE,
    CLEAR_LINE,
    CLEAR_ALL
  } state_t;

endpackage

// File: rtl/vga_console_if.sv
// Character stream in, character-RAM write port out; master is the console controller side.
interface vga_console_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ROW_W  = 6,
  parameter int unsigned COL_W  = 6
);

  logic [DATA_W-1:0]      char_i;
  logic                   char_valid_i;
  logic                   char_ready_o;
  logic                   ram_we_o;
  logic [ROW_W+COL_W-1:0] ram_waddr_o;
  logic [DATA_W-1:0]      ram_wdata_o;

  modport master (
    input  char_i, char_valid_i,
    output char_ready_o, ram_we_o, ram_waddr_o, ram_wdata_o
  );

  modport slave (
    output char_i, char_valid_i,
    input  char_ready_o, ram_we_o, ram_waddr_o, ram_wdata_o
  );

endinterface

// File: rtl/vga_clear_sweep.sv
// Loadable address sweep: steps from start through len consecutive addresses, done pulses after the last.
module vga_clear_sweep #(
  parameter int unsigned ADDR_W = 12,
  parameter logic [ADDR_W:0] RESET_LEN = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] start,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr
);

  localparam int unsigned LEN_W = ADDR_W + 1;

  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  remain_q;
  logic              done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      remain_q <= RESET_LEN;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        addr_q   <= start;
        remain_q <= len;
      end else if (step && busy) begin
        addr_q   <= addr_q + ADDR_W'(1);
        remain_q <= remain_q - LEN_W'(1);
        done_q   <= (remain_q == LEN_W'(1));
      end
    end
  end

  assign busy = (remain_q != '0);
  assign done = done_q;
  assign addr = addr_q;

endmodule

// File: rtl/vga_console.sv
// Text-console write controller: cursor, control codes, ring-buffer scrolling and RAM clears.
module vga_console
  import vga_console_pkg::*;
#(
  parameter int unsigned COLS      = 59,
  parameter int unsigned ROWS      = 29,
  parameter int unsigned COL_W     = 6,
  parameter int unsigned ROW_W     = 6,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned TAB_W     = 4,
  parameter bit          SCROLL_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  vga_console_if.master          bus,
  input  logic [ROW_W-1:0]       rd_row_i,
  input  logic [COL_W-1:0]       rd_col_i,
  output logic [ROW_W+COL_W-1:0] rd_addr_o,
  output logic [ROW_W-1:0]       cursor_row_o,
  output logic [COL_W-1:0]       cursor_col_o,
  output logic [ROW_W-1:0]       base_o
);

  localparam int unsigned ADDR_W = ROW_W + COL_W;
  localparam int unsigned LEN_W  = ADDR_W + 1;
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(1) << ADDR_W;
  localparam logic [LEN_W-1:0] LINE_LEN = LEN_W'(1) << COL_W;

  state_t state_q, state_d;

  logic [ROW_W-1:0]  row_q, row_d, base_q, base_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              sw_load, sw_step, sw_busy, sw_done;
  logic [ADDR_W-1:0] sw_start, sw_addr;
  logic [LEN_W-1:0]  sw_len;

  logic [ROW_W-1:0]  cur_phys, nl_row, nl_base, nl_phys, rd_phys;
  logic [COL_W:0]    tab_col;
  logic              do_nl, clr_head, char_ready;

  vga_clear_sweep #(
    .ADDR_W    (ADDR_W),
    .RESET_LEN (FULL_LEN)
  ) u_sweep (
    .clk   (clk),
    .rst   (rst),
    .load  (sw_load),
    .step  (sw_step),
    .start (sw_start),
    .len   (sw_len),
    .busy  (sw_busy),
    .done  (sw_done),
    .addr  (sw_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= INIT_CLEAR;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q   <= '0;
      col_q   <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      base_q  <= base_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    base_d   = base_q;
    we_d     = 1'b0;
    waddr_d  = '0;
    wdata_d  = '0;
    sw_load  = 1'b0;
    sw_step  = 1'b0;
    sw_start = '0;
    sw_len   = '0;
    do_nl    = 1'b0;
    clr_head = 1'b0;

    cur_phys = base_q + row_q;
    nl_row   = row_q;
    nl_base  = base_q;
    if (row_q < ROW_W'(ROWS - 1)) nl_row  = row_q + ROW_W'(1);
    else if (SCROLL_EN)           nl_base = base_q + ROW_W'(1);
    else                          nl_row  = '0;
    nl_phys = nl_base + nl_row;
    tab_col = ({1'b0, col_q} | (COL_W + 1)'(TAB_W - 1)) + (COL_W + 1)'(1);

    case (state_q)
      IDLE: begin
        if (bus.char_valid_i) begin
          if (bus.char_i == DATA_W'(CH_LF)) begin
            do_nl    = 1'b1;
            clr_head = 1'b1;
          end else if (bus.char_i == DATA_W'(CH_CR)) begin
            col_d = '0;
          end else if (bus.char_i == DATA_W'(CH_BS)) begin
            if (col_q != '0) begin
              col_d   = col_q - COL_W'(1);
              we_d    = 1'b1;
              waddr_d = {cur_phys, col_q - COL_W'(1)};
            end
          end else if (bus.char_i == DATA_W'(CH_TAB)) begin
            if (tab_col >= (COL_W + 1)'(COLS)) begin
              do_nl    = 1'b1;
              clr_head = 1'b1;
            end else begin
              col_d = tab_col[COL_W-1:0];
            end
          end else if (bus.char_i == DATA_W'(CH_FF)) begin
            base_d   = '0;
            row_d    = '0;
            col_d    = '0;
            state_d  = CLEAR_ALL;
            sw_load  = 1'b1;
            sw_len   = FULL_LEN;
          end else begin
            we_d    = 1'b1;
            waddr_d = {cur_phys, col_q};
            wdata_d = bus.char_i;
            if (col_q < COL_W'(COLS - 1)) col_d = col_q + COL_W'(1);
            else                          do_nl = 1'b1;
          end

          // Without a char write the write port is free, so column 0 of the
          // new line is cleared straight away and the sweep covers the rest.
          if (do_nl) begin
            row_d   = nl_row;
            base_d  = nl_base;
            col_d   = '0;
            state_d = CLEAR_LINE;
            sw_load = 1'b1;
            if (clr_head) begin
              we_d     = 1'b1;
              waddr_d  = {nl_phys, {COL_W{1'b0}}};
              wdata_d  = '0;
              sw_start = {nl_phys, COL_W'(1)};
              sw_len   = LINE_LEN - LEN_W'(1);
            end else begin
              sw_start = {nl_phys, {COL_W{1'b0}}};
              sw_len   = LINE_LEN;
            end
          end
        end
      end
      default: begin
        if (sw_done) begin
          state_d = IDLE;
        end else if (sw_busy) begin
          we_d    = 1'b1;
          waddr_d = sw_addr;
          sw_step = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    char_ready = (state_q == IDLE);
    rd_phys    = base_q + rd_row_i;
  end

  assign bus.char_ready_o = char_ready;
  assign bus.ram_we_o     = we_q;
  assign bus.ram_waddr_o  = waddr_q;
  assign bus.ram_wdata_o  = wdata_q;
  assign rd_addr_o        = {rd_phys, rd_col_i};
  assign cursor_row_o     = row_q;
  assign cursor_col_o     = col_q;
  assign base_o           = base_q;

endmodule

// File: tb/tb_vga_console.sv
// Directed bench for vga_console: RAM writes are scoreboarded against a queue of expected (cycle, addr, data).
module tb_vga_console;
  import vga_console_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned acc = 0;

  typedef struct {
    int unsigned cyc;
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;
  wr_t exp_q[$];

  vga_console_if #(.DATA_W(8), .ROW_W(6), .COL_W(6)) bus ();
  vga_console_if #(.DATA_W(8), .ROW_W(6), .COL_W(6)) bus2 ();

  logic [5:0]  rd_row = '0, rd_col = '0;
  logic [11:0] rd_addr, rd_addr2;
  logic [5:0]  cur_row, cur_col, base, cur_row2, cur_col2, base2;

  vga_console #(
    .COLS(59), .ROWS(29), .COL_W(6), .ROW_W(6), .DATA_W(8), .TAB_W(4), .SCROLL_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .rd_row_i(rd_row), .rd_col_i(rd_col), .rd_addr_o(rd_addr),
    .cursor_row_o(cur_row), .cursor_col_o(cur_col), .base_o(base)
  );

  vga_console #(
    .COLS(59), .ROWS(29), .COL_W(6), .ROW_W(6), .DATA_W(8), .TAB_W(4), .SCROLL_EN(1'b0)
  ) dut_wrap (
    .clk(clk), .rst(rst), .bus(bus2),
    .rd_row_i(rd_row), .rd_col_i(rd_col), .rd_addr_o(rd_addr2),
    .cursor_row_o(cur_row2), .cursor_col_o(cur_col2), .base_o(base2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  task automatic push_w(input int unsigned c, input int unsigned a, input logic [7:0] d);
    wr_t e;
    e.cyc  = c;
    e.addr = a[11:0];
    e.data = d;
    exp_q.push_back(e);
  endtask

  // c0 == 0 queues the writes without a cycle constraint
  task automatic push_sweep(input int unsigned c0, input int unsigned a0, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) push_w((c0 == 0) ? 0 : c0 + k, a0 + k, 8'h00);
  endtask

  // Called at a negedge; returns before the accepting edge with acc set to its cycle index.
  task automatic drive(input logic [7:0] c);
    int unsigned n = 0;
    bus.char_i       = c;
    bus.char_valid_i = 1'b1;
    while (bus.char_ready_o !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_accept", bus.char_ready_o, 1);
    acc = cyc + 1;
  endtask

  task automatic commit();
    @(negedge clk);
    bus.char_valid_i = 1'b0;
  endtask

  task automatic send(input logic [7:0] c);
    drive(c);
    commit();
  endtask

  task automatic wait_ready(output int unsigned low);
    low = 0;
    while (bus.char_ready_o !== 1'b1 && low < 6000) begin
      @(negedge clk);
      low++;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.ram_we_o === 1'b1) begin
      wr_t e;
      logic ok;
      int unsigned qn;
      qn = exp_q.size();
      e  = '{cyc: 0, addr: '0, data: '0};
      ok = 1'b0;
      if (qn != 0) begin
        e  = exp_q.pop_front();
        ok = (e.cyc == 0 || e.cyc == cyc) && bus.ram_waddr_o === e.addr && bus.ram_wdata_o === e.data;
      end
      checks++;
      assert (ok) passes++;
      else $error("FAIL ram_write cyc=%0d addr=0x%03h data=0x%02h, expected cyc=%0d addr=0x%03h data=0x%02h (queued=%0d)",
                  cyc, bus.ram_waddr_o, bus.ram_wdata_o, e.cyc, e.addr, e.data, qn);
    end
  end

  initial begin
    int unsigned r0, low, n;
    bus.char_i        = '0;
    bus.char_valid_i  = 1'b0;
    bus2.char_i       = '0;
    bus2.char_valid_i = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_we", bus.ram_we_o, 0);
    check("rst_ready", bus.char_ready_o, 0);
    check("rst_waddr", bus.ram_waddr_o, 0);
    check("rst_row", cur_row, 0);
    check("rst_col", cur_col, 0);
    check("rst_base", base, 0);
    check("rst_rd_addr", rd_addr, 0);

    r0 = cyc + 1;
    push_sweep(r0, 0, 4096);
    rst = 1'b0;
    wait_ready(low);
    check("init_ready_rise_cycle", cyc, r0 + 4096);
    check("init_sweep_drained", exp_q.size(), 0);

    drive(8'h41); push_w(acc, 12'h000, 8'h41); commit();
    drive(8'h42); push_w(acc, 12'h001, 8'h42); commit();
    check("ab_col", cur_col, 2);
    check("ab_row", cur_row, 0);

    send(CH_CR);
    check("cr_col", cur_col, 0);

    for (int unsigned i = 0; i < 59; i++) begin
      drive(8'(8'h30 + i));
      push_w(acc, i, 8'(8'h30 + i));
      if (i == 58) push_sweep(acc + 1, 12'h040, 64);
      commit();
    end
    wait_ready(low);
    check("wrap_ready_low_cycles", low, 65);
    check("wrap_row", cur_row, 1);
    check("wrap_col", cur_col, 0);

    send(CH_BS);
    check("bs_col0_no_write", bus.ram_we_o, 0);
    check("bs_col0_ready", bus.char_ready_o, 1);
    check("bs_col0_col", cur_col, 0);
    check("bs_col0_row", cur_row, 1);

    for (int unsigned i = 0; i < 5; i++) begin
      drive(8'(8'h61 + i)); push_w(acc, 12'h040 + i, 8'(8'h61 + i)); commit();
    end
    check("row1_col", cur_col, 5);
    drive(CH_BS); push_w(acc, 12'h044, 8'h00); commit();
    check("bs_col", cur_col, 4);

    send(CH_TAB);
    check("tab_col4", cur_col, 8);
    for (int unsigned i = 0; i < 12; i++) send(CH_TAB);
    check("tab_col56", cur_col, 56);
    drive(8'h78); push_w(acc, 12'h040 + 56, 8'h78); commit();
    check("col57", cur_col, 57);
    drive(CH_TAB); push_sweep(acc, 12'h080, 64); commit();
    wait_ready(low);
    check("tab_nl_ready_low_cycles", low, 64);
    check("tab_nl_row", cur_row, 2);
    check("tab_nl_col", cur_col, 0);

    for (int unsigned r = 2; r < 28; r++) begin
      drive(CH_LF); push_sweep(acc, (r + 1) * 64, 64); commit();
      wait_ready(low);
      check("lf_ready_low_cycles", low, 64);
    end
    check("lf_row28", cur_row, 28);
    check("lf_base0", base, 0);

    drive(CH_LF); push_sweep(acc, 12'h740, 64); commit();
    check("scroll_base", base, 1);
    check("scroll_row", cur_row, 28);
    wait_ready(low);
    #1;
    check("rd_addr_row0", rd_addr, 12'h040);
    rd_row = 6'd63; rd_col = 6'd5;
    #1;
    check("rd_addr_ring_wrap", rd_addr, 12'h005);
    rd_row = '0; rd_col = '0;
    @(negedge clk);
    drive(8'h5A); push_w(acc, 12'h740, 8'h5A); commit();
    check("scroll_write_col", cur_col, 1);

    drive(CH_FF); push_sweep(0, 0, 4096); commit();
    check("ff_base", base, 0);
    check("ff_row", cur_row, 0);
    check("ff_col", cur_col, 0);
    wait_ready(low);
    check("ff_sweep_drained", exp_q.size(), 0);

    drive(CH_LF); push_sweep(acc, 12'h040, 64); commit();
    repeat (10) @(negedge clk);
    #2;
    exp_q.delete();
    rst = 1'b1;
    #1;
    check("midreset_we", bus.ram_we_o, 0);
    check("midreset_row", cur_row, 0);
    check("midreset_col", cur_col, 0);
    check("midreset_ready", bus.char_ready_o, 0);
    @(negedge clk);
    r0 = cyc + 1;
    push_sweep(r0, 0, 4096);
    rst = 1'b0;
    wait_ready(low);
    check("reinit_ready_rise_cycle", cyc, r0 + 4096);

    for (int unsigned i = 0; i < 29; i++) begin
      bus2.char_i       = CH_LF;
      bus2.char_valid_i = 1'b1;
      n = 0;
      while (bus2.char_ready_o !== 1'b1 && n < 6000) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
      bus2.char_valid_i = 1'b0;
      if (i == 27) begin
        check("noscroll_row28", cur_row2, 28);
        check("noscroll_base_at28", base2, 0);
      end
    end
    check("noscroll_wrap_row", cur_row2, 0);
    check("noscroll_wrap_base", base2, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
